// File: rtl/sum_pipe_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   SLICE_W      : bits resolved per lookahead slice (one slice per stage)
//   MIN_WIDTH    : smallest supported operand width
//   gate_op_e    : function selector for the sum_gate_p power-counted gate
//   stage_count  : number of pipeline stages for a given operand width
//   width_ok     : operand width legality check (multiple of SLICE_W, >= MIN_WIDTH)
package sum_pipe_cla_pkg;

  localparam int unsigned SLICE_W   = 4;
  localparam int unsigned MIN_WIDTH = 8;

  typedef enum logic [1:0] {
    GATE_AND = 2'd0,
    GATE_OR  = 2'd1,
    GATE_XOR = 2'd2
  } gate_op_e;

  function automatic int unsigned stage_count(input int unsigned width);
    return width / SLICE_W;
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= MIN_WIDTH) && ((width % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/sum_pipe_cla_if.sv
// Operand/result handshake bundle for sum_pipe_cla.
//   in_valid/in_ready   : operand word handshake (a, b, ci, sub)
//   out_valid/out_ready : result handshake (s, co, ovf)
// master = producer of operands / consumer of results; slave = the adder.
interface sum_pipe_cla_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/sum_gate_p.sv
// Power-counted N-input gate primitive (AND / OR / XOR reduction).
//   OP   : gate function
//   N    : number of inputs
//   PwrC : power-count parameter consumed by power analysis
//   i    : gate inputs
//   y    : gate output
module sum_gate_p
  import sum_pipe_cla_pkg::*;
#(
  parameter gate_op_e    OP   = GATE_AND,
  parameter int unsigned N    = 2,
  parameter int          PwrC = 0
) (
  input  logic [N-1:0] i,
  output logic         y
);

  if (PwrC < 0) begin : g_bad_pwrc
    $error("sum_gate_p: PwrC must be non-negative");
  end

  case (OP)
    GATE_AND: begin : g_and
      assign y = &i;
    end
    GATE_OR: begin : g_or
      assign y = |i;
    end
    default: begin : g_xor
      assign y = ^i;
    end
  endcase

endmodule

// File: rtl/sum_slice_cla.sv
// Combinational 4-bit carry-lookahead slice built from sum_gate_p gates.
//   a, b : slice operand bits (b already sub-adjusted by the caller)
//   ci   : carry into bit 0 of the slice
//   s    : slice sum bits
//   c4   : carry out of the slice
//   c3   : carry into the slice MSB (used for two's-complement overflow)
module sum_slice_cla
  import sum_pipe_cla_pkg::*;
#(
  parameter int PwrC = 0
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               c4,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               t1;
  logic [1:0]         t2;
  logic [2:0]         t3;
  logic [3:0]         t4;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    sum_gate_p #(.OP(GATE_AND), .N(2), .PwrC(PwrC)) u_g (.i({a[i], b[i]}), .y(g[i]));
    sum_gate_p #(.OP(GATE_XOR), .N(2), .PwrC(PwrC)) u_p (.i({a[i], b[i]}), .y(p[i]));
    sum_gate_p #(.OP(GATE_XOR), .N(2), .PwrC(PwrC)) u_s (.i({p[i], c[i]}), .y(s[i]));
  end

  // Every carry is a flat sum of products of g/p and ci, so no carry
  // depends on another carry inside the slice.
  sum_gate_p #(.OP(GATE_AND), .N(2), .PwrC(PwrC)) u_t1_0 (.i({p[0], ci}), .y(t1));
  sum_gate_p #(.OP(GATE_OR),  .N(2), .PwrC(PwrC)) u_c1   (.i({g[0], t1}), .y(c[1]));

  sum_gate_p #(.OP(GATE_AND), .N(2), .PwrC(PwrC)) u_t2_0 (.i({p[1], g[0]}), .y(t2[0]));
  sum_gate_p #(.OP(GATE_AND), .N(3), .PwrC(PwrC)) u_t2_1 (.i({p[1], p[0], ci}), .y(t2[1]));
  sum_gate_p #(.OP(GATE_OR),  .N(3), .PwrC(PwrC)) u_c2   (.i({g[1], t2}), .y(c[2]));

  sum_gate_p #(.OP(GATE_AND), .N(2), .PwrC(PwrC)) u_t3_0 (.i({p[2], g[1]}), .y(t3[0]));
  sum_gate_p #(.OP(GATE_AND), .N(3), .PwrC(PwrC)) u_t3_1 (.i({p[2], p[1], g[0]}), .y(t3[1]));
  sum_gate_p #(.OP(GATE_AND), .N(4), .PwrC(PwrC)) u_t3_2 (.i({p[2], p[1], p[0], ci}), .y(t3[2]));
  sum_gate_p #(.OP(GATE_OR),  .N(4), .PwrC(PwrC)) u_c3   (.i({g[2], t3}), .y(c[3]));

  sum_gate_p #(.OP(GATE_AND), .N(2), .PwrC(PwrC)) u_t4_0 (.i({p[3], g[2]}), .y(t4[0]));
  sum_gate_p #(.OP(GATE_AND), .N(3), .PwrC(PwrC)) u_t4_1 (.i({p[3], p[2], g[1]}), .y(t4[1]));
  sum_gate_p #(.OP(GATE_AND), .N(4), .PwrC(PwrC)) u_t4_2 (.i({p[3], p[2], p[1], g[0]}), .y(t4[2]));
  sum_gate_p #(.OP(GATE_AND), .N(5), .PwrC(PwrC)) u_t4_3 (.i({p[3], p[2], p[1], p[0], ci}), .y(t4[3]));
  sum_gate_p #(.OP(GATE_OR),  .N(5), .PwrC(PwrC)) u_c4   (.i({g[3], t4}), .y(c[4]));

  assign c4 = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/sum_pipe_cla.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit slice per stage.
//   WIDTH   : operand/result width (multiple of SLICE, >= 8)
//   SLICE   : bits per lookahead slice (must be 4)
//   PwrC    : power-count parameter passed to every gate
//   clk     : clock, rising edge
//   reset_L : synchronous active-low reset
//   bus     : slave side of sum_pipe_cla_if
//             in  : in_valid, a, b, ci, sub, out_ready
//             out : in_ready, out_valid, s, co, ovf
// Latency is WIDTH/SLICE cycles from acceptance to out_valid; one word per
// cycle while out_ready is high; the whole pipe stalls when out_ready is low.
module sum_pipe_cla
  import sum_pipe_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4,
  parameter int          PwrC  = 0
) (
  input  logic          clk,
  input  logic          reset_L,
  sum_pipe_cla_if.slave bus
);

  localparam int unsigned L = stage_count(WIDTH);

  if (!width_ok(WIDTH) || (SLICE != SLICE_W)) begin : g_bad_cfg
    $error("sum_pipe_cla: WIDTH must be a multiple of 4 and >= 8, SLICE must be 4");
  end

  // Stage k holds the operands still to be summed, the carry into slice k
  // and the sum bits already resolved by slices 0..k-1.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           st    [L];
  logic [SLICE-1:0] sl_s  [L];
  logic             sl_c4 [L];
  logic             sl_c3 [L];
  logic             en;

  // One global enable: the output slot frees up either because it is empty
  // or because it is being consumed this cycle.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < L; k++) begin : g_stage
    sum_slice_cla #(.PwrC(PwrC)) u_slice (
      .a  (st[k].a[SLICE*k +: SLICE]),
      .b  (st[k].b[SLICE*k +: SLICE]),
      .ci (st[k].c),
      .s  (sl_s[k]),
      .c4 (sl_c4[k]),
      .c3 (sl_c3[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int unsigned k = 0; k < L; k++) begin
        st[k] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.s         <= '0;
      bus.co        <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (en) begin
      // Subtraction becomes A + ~B + 1 here, so the slices only ever add.
      st[0].v <= bus.in_valid;
      st[0].c <= bus.sub | bus.ci;
      st[0].s <= '0;
      st[0].a <= bus.a;
      st[0].b <= bus.b ^ {WIDTH{bus.sub}};

      for (int unsigned k = 1; k < L; k++) begin
        st[k].v <= st[k-1].v;
        st[k].c <= sl_c4[k-1];
        st[k].a <= st[k-1].a;
        st[k].b <= st[k-1].b;
        st[k].s <= st[k-1].s | (WIDTH'(sl_s[k-1]) << (SLICE * (k - 1)));
      end

      // Bubbles leave s/co/ovf untouched so only complete results show.
      bus.out_valid <= st[L-1].v;
      if (st[L-1].v) begin
        bus.s   <= st[L-1].s | (WIDTH'(sl_s[L-1]) << (SLICE * (L - 1)));
        bus.co  <= sl_c4[L-1];
        bus.ovf <= sl_c3[L-1] ^ sl_c4[L-1];
      end
    end
  end

endmodule

// File: tb/tb_sum_pipe_cla.sv
// Directed self-checking bench for sum_pipe_cla (WIDTH=16, four stages).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected results are hand-computed and queued at
// acceptance; the output monitor pops them in order.
module tb_sum_pipe_cla;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic reset_L;

  sum_pipe_cla_if #(.WIDTH(WIDTH)) bus ();

  sum_pipe_cla #(.WIDTH(WIDTH), .SLICE(4), .PwrC(0)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: in-order result check plus hold-stable check on stalls.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] held_s;
  logic             held_co;
  logic             held_ovf;
  exp_t             e;

  always @(negedge clk) begin
    if (reset_L === 1'b1) begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_s",     32'(bus.s),         32'(held_s));
        check("hold_co",    32'(bus.co),        32'(held_co));
        check("hold_ovf",   32'(bus.ovf),       32'(held_ovf));
      end
      if (bus.out_valid && !bus.out_ready) begin
        check("in_ready_stall", 32'(bus.in_ready), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_s",   32'(bus.s),   32'(e.s));
          check("res_co",  32'(bus.co),  32'(e.co));
          check("res_ovf", 32'(bus.ovf), 32'(e.ovf));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_s     = bus.s;
      held_co    = bus.co;
      held_ovf   = bus.ovf;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at posedge+1; in_ready is judged at posedge+2 so any
  // out_ready change made at posedge+1 has settled.
  task automatic send(input string tag,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic sub,
                      input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    logic ok;
    ok           = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back('{s: es, co: eco, ovf: eovf});
      end
      @(posedge clk);
      #1;
      if (ok) break;
      #1;
    end
    bus.in_valid = 1'b0;
    check({"accept_", tag}, 32'(ok), 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h4321;
    bus.ci        = 1'b1;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held two edges with a valid word offered.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_s",         32'(bus.s),         0);
    check("rst_co",        32'(bus.co),        0);
    check("rst_ovf",       32'(bus.ovf),       0);
    reset_L      = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  32'(bus.in_ready),  1);
    check("post_rst_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;

    // Directed arithmetic corners.
    send("add_carry",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send("add_wrap",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send("sub_ci_ign",  16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);
    drain("directed");

    // Eight back-to-back words with a three-cycle out_ready stall.
    fork
      begin
        send("w0", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        send("w1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send("w2", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        send("w3", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send("w4", 16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
        send("w5", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        send("w6", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send("w7", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("stream");

    // Reset with three words in flight: none of them may appear.
    send("f0", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
    send("f1", 16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0);
    send("f2", 16'h0606, 16'h0707, 1'b0, 1'b0, 16'h0D0D, 1'b0, 1'b0);
    reset_L = 1'b0;
    exp_q.delete();
    idle(1);
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_out_valid", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
    end

    // Latency of the first word after reset: out_valid exactly four edges on.
    send("lat", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat_early", 32'(bus.out_valid), 0);
    end
    @(negedge clk);
    check("lat_due", 32'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    drain("lat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_pipe_cla.md
# sum_pipe_cla

Parametrised, pipelined carry-lookahead adder/subtractor for operand widths beyond 8 bits. Operands are split into SLICE-bit lookahead slices, one slice resolved per pipeline stage, with carries rippling stage to stage through registers. A valid/ready handshake on both sides gives full throughput with back-pressure. Every gate carries the PwrC power-count parameter so power analysis runs on it unchanged.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE, minimum 8
- SLICE, 4, bits per lookahead slice; fixed at 4 in this generation
- PwrC, 0, power-count parameter passed to every gate instance
- clk  in  1  single clock; all state updates on rising edge
- reset_L  in  1  reset, synchronous and active-low
- in_valid  in  1  operand word present
- in_ready  out  1  block accepts operand word this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry in; ignored when sub=1
- sub  in  1  0 = A+B+ci, 1 = A−B (A + ~B + 1)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- co  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  two's-complement overflow: carry into MSB xor carry out of MSB

## Operation
- L = WIDTH/SLICE pipeline stages. Stage k computes slice k (bits 4k+3..4k) from registered A/B slice, registered carry and sub-adjusted B.
- Each stage register holds valid bit, carry, partial sum bits 0..4k+3, unprocessed upper A/B bits, sub-adjusted flag. Low-order results shift forward; upper operand bits are carried unchanged.
- Sub handling at input: B' = B xor {WIDTH{sub}}, c_in = sub ? 1 : ci; slices see only B' and carry.
- Last stage additionally registers carry into MSB so ovf is formed at the output register.
- Global advance enable: en = !out_valid || out_ready. in_ready = en. All stages shift when en=1; hold when en=0. Bubbles are not compressed.
- Input accepted on edge where in_valid && in_ready; invalid slots enter as valid=0 and still propagate.
- Output register holds s/co/ovf stable while out_valid && !out_ready.
- Reset (reset_L=0 at an edge): all stage valid bits 0, out_valid=0, s=0, co=0, ovf=0, in_ready=1 the cycle after reset. In-flight words are discarded; no partial result ever appears.

## Timing
- Latency: word accepted at edge n appears with out_valid=1 after edge n+L (L=4 for WIDTH=16).
- Throughput: one word per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready; no other comb path from inputs to outputs.
- Simultaneous out_ready deassert and in_valid: word is not accepted (in_ready=0); upstream holds.
- Carry wrap: co reflects MSB carry only; s is modulo 2^WIDTH.
- reset_L low during stall: reset wins; pipeline empties regardless of out_ready.

## Structure
- Shared include sum_defs.vh: SLICE constant, stage-count macro, WIDTH-multiple check.
- Sub-module sum_slice_cla: combinational 4-bit lookahead slice (g/p, carry chain, xor sum, outputs s[3:0], c4 and c3 for ovf), built from the *_p gate primitives with PwrC.
- Top instantiates L copies of sum_slice_cla via generate; stage registers in the top.

## Test plan
- Reset: hold reset_L=0 two edges with in_valid=1 -> out_valid=0, s=0, co=0, ovf=0; in_ready=1 after release.
- WIDTH=16 add 16'h00FF + 16'h0001, ci=0 -> 4 cycles later s=16'h0100, co=0, ovf=0; 16'hFFFF+16'h0000, ci=1 -> s=16'h0000, co=1, ovf=0.
- Subtract 16'h0005 − 16'h0007 -> s=16'hFFFE, co=0, ovf=0; 16'h8000 − 16'h0001 -> s=16'h7FFF, co=1, ovf=1.
- Signed add overflow 16'h7FFF + 16'h0001 -> s=16'h8000, co=0, ovf=1.
- Back-to-back 8 words, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, outputs held stable, all 8 results emitted in order, none lost or duplicated.
- Reset mid-stream with 3 words in flight -> no out_valid for those words; next accepted word emerges after exactly L cycles with correct result.
